// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch front end: RV32I opcodes, the bubble word,
// the fetch FSM encoding and the register-usage helpers used by hazard detection.
package if_id_stage_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    // U-type and JAL carry immediate bits where rs1 would sit.
    function automatic logic reads_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opcode);
        return (opcode == OP_R || opcode == OP_S || opcode == OP_B);
    endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Combinational load-use detector: flags when the instruction in ID reads the
// register a load currently in EX is about to write.
module hazard_detect
    import if_id_stage_pkg::*;
(
    input  logic [31:0] ID_inst,
    input  logic        ID_valid,
    input  logic        EX_load,
    input  logic [4:0]  EX_rd,
    output logic        haz
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_bits;

    assign opcode = ID_inst[6:0];
    assign rs1    = ID_inst[19:15];
    assign rs2    = ID_inst[24:20];

    assign rs1_hit = reads_rs1(opcode) && (rs1 == EX_rd);
    assign rs2_hit = reads_rs2(opcode) && (rs2 == EX_rd);

    // x0 is never really written, so a load to x0 cannot create a dependency.
    assign haz = EX_load && (EX_rd != 5'd0) && ID_valid && (rs1_hit || rs2_hit);

    assign unused_bits = ^{ID_inst[31:25], ID_inst[14:7]};

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end: PC register, IF/ID pipeline register, load-use stall and EX
// redirect handling. Optional perf counters are enabled by IF_ID_PERF_CNT_EN.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = if_id_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_inst_i,
    input  logic        EX_jump_i,
    input  logic [31:0] EX_target_i,
    input  logic        EX_load_i,
    input  logic [4:0]  EX_rd_i,
    output logic [31:0] IF_pc_o,
    output logic [31:0] ID_pc_o,
    output logic [31:0] ID_pc4_o,
    output logic [31:0] ID_inst_o,
    output logic        ID_valid_o,
    output logic        stop_o,
    output logic        flush_o
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0] pc_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_inst_q;
    logic        id_valid_q;
    logic        haz;
    logic        redirect;
    logic [31:0] target_aligned;

    hazard_detect u_hazard_detect (
        .ID_inst  (id_inst_q),
        .ID_valid (id_valid_q),
        .EX_load  (EX_load_i),
        .EX_rd    (EX_rd_i),
        .haz      (haz)
    );

    // EX still holds reset state during BOOT, so any jump it reports is spurious.
    assign redirect       = EX_jump_i && (state != BOOT);
    assign target_aligned = EX_target_i & ~32'h3;

    assign flush_o = redirect;
    assign stop_o  = haz && !EX_jump_i;

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT: state_nxt = RUN;
            RUN, STALL, FLUSH: begin
                if (redirect)
                    state_nxt = FLUSH;
                else if (haz)
                    state_nxt = STALL;
                else
                    state_nxt = RUN;
            end
            default: state_nxt = BOOT;
        endcase
    end

    // A squash leaves ID_pc untouched; only the instruction and valid bit are bubbled.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= BOOT;
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'h0000_0000;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc_q       <= target_aligned;
                id_inst_q  <= NOP_INST;
                id_valid_q <= 1'b0;
            end else if (!stop_o) begin
                pc_q       <= pc_q + 32'd4;
                id_pc_q    <= pc_q;
                id_inst_q  <= IF_inst_i;
                id_valid_q <= 1'b1;
            end
        end
    end

    assign IF_pc_o    = pc_q;
    assign ID_pc_o    = id_pc_q;
    assign ID_pc4_o   = id_pc_q + 32'd4;
    assign ID_inst_o  = id_inst_q;
    assign ID_valid_o = id_valid_q;

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_cnt_o <= 32'h0000_0000;
            flush_cnt_o <= 32'h0000_0000;
        end else begin
            if (stop_o && stall_cnt_o != 32'hFFFF_FFFF)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_o && flush_cnt_o != 32'hFFFF_FFFF)
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed pipeline scenarios with literal
// expectations followed by random stimulus checked against a behavioural model.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] IF_inst_i;
    logic        EX_jump_i;
    logic [31:0] EX_target_i;
    logic        EX_load_i;
    logic [4:0]  EX_rd_i;
    logic [31:0] IF_pc_o;
    logic [31:0] ID_pc_o;
    logic [31:0] ID_pc4_o;
    logic [31:0] ID_inst_o;
    logic        ID_valid_o;
    logic        stop_o;
    logic        flush_o;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;
`endif

    logic [31:0] romTable [256];

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model of the architecturally visible fetch state.
    logic [31:0] mPc, mIdPc, mIdInst;
    logic        mIdValid, mBoot, mKnown;
    logic [31:0] mStallCnt, mFlushCnt;

    if_id_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .IF_inst_i   (IF_inst_i),
        .EX_jump_i   (EX_jump_i),
        .EX_target_i (EX_target_i),
        .EX_load_i   (EX_load_i),
        .EX_rd_i     (EX_rd_i),
        .IF_pc_o     (IF_pc_o),
        .ID_pc_o     (ID_pc_o),
        .ID_pc4_o    (ID_pc4_o),
        .ID_inst_o   (ID_inst_o),
        .ID_valid_o  (ID_valid_o),
        .stop_o      (stop_o),
        .flush_o     (flush_o)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt_o (stallCnt),
        .flush_cnt_o (flushCnt)
`endif
    );

    assign IF_inst_i = romTable[IF_pc_o[9:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic hazModel(input logic [31:0] inst, input logic valid,
                                      input logic load, input logic [4:0] rd);
        logic [6:0] op;
        logic       rs1Used, rs2Used;
        op      = inst[6:0];
        rs1Used = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        rs2Used = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return load && rd != 5'd0 && valid &&
               ((rs1Used && inst[19:15] == rd) || (rs2Used && inst[24:20] == rd));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic jump, input logic [31:0] target,
                                 input logic load, input logic [4:0] rd);
        @(negedge clk);
        rst_n       = rst;
        EX_jump_i   = jump;
        EX_target_i = target;
        EX_load_i   = load;
        EX_rd_i     = rd;
        #3;
    endtask

    // Compare process: outputs are checked mid-low-phase, model advances on each rising edge.
    initial begin
        logic stopNow, flushNow;
        mKnown    = 1'b0;
        mBoot     = 1'b1;
        mPc       = '0;
        mIdPc     = '0;
        mIdInst   = NOP;
        mIdValid  = 1'b0;
        mStallCnt = '0;
        mFlushCnt = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mKnown) begin
                stopNow  = hazModel(mIdInst, mIdValid, EX_load_i, EX_rd_i) && !EX_jump_i;
                flushNow = !mBoot && EX_jump_i;
                checkOutput("IF_pc", IF_pc_o, mPc);
                checkOutput("ID_pc", ID_pc_o, mIdPc);
                checkOutput("ID_pc4", ID_pc4_o, mIdPc + 32'd4);
                checkOutput("ID_inst", ID_inst_o, mIdInst);
                checkOutput("ID_valid", {31'b0, ID_valid_o}, {31'b0, mIdValid});
                checkOutput("stop", {31'b0, stop_o}, {31'b0, stopNow});
                checkOutput("flush", {31'b0, flush_o}, {31'b0, flushNow});
`ifdef IF_ID_PERF_CNT_EN
                checkOutput("stall_cnt", stallCnt, mStallCnt);
                checkOutput("flush_cnt", flushCnt, mFlushCnt);
`endif
            end
            @(posedge clk);
            if (rst_n) begin
                mKnown    = 1'b1;
                mBoot     = 1'b1;
                mPc       = 32'h0;
                mIdPc     = 32'h0;
                mIdInst   = NOP;
                mIdValid  = 1'b0;
                mStallCnt = '0;
                mFlushCnt = '0;
            end else if (mKnown) begin
                stopNow  = hazModel(mIdInst, mIdValid, EX_load_i, EX_rd_i) && !EX_jump_i;
                flushNow = !mBoot && EX_jump_i;
                if (stopNow && mStallCnt != 32'hFFFF_FFFF) mStallCnt = mStallCnt + 1;
                if (flushNow && mFlushCnt != 32'hFFFF_FFFF) mFlushCnt = mFlushCnt + 1;
                if (flushNow) begin
                    mPc      = {EX_target_i[31:2], 2'b00};
                    mIdInst  = NOP;
                    mIdValid = 1'b0;
                end else if (!stopNow) begin
                    mIdPc    = mPc;
                    mIdInst  = romTable[mPc[9:2]];
                    mIdValid = 1'b1;
                    mPc      = mPc + 32'd4;
                end
                mBoot = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [31:0] cur;
        logic [6:0]  ops [8];
        ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b0010011, 7'b0000011};
        for (int i = 0; i < 256; i++) begin
            w         = $urandom;
            w[6:0]    = ops[$urandom_range(0, 7)];
            w[19:15]  = 5'($urandom_range(0, 7));
            w[24:20]  = 5'($urandom_range(0, 7));
            romTable[i] = w;
        end
        romTable[0]   = 32'h0012_8333;   // add  x6,x5,x1
        romTable[1]   = 32'h0051_2023;   // sw   x5,0(x2)
        romTable[2]   = 32'h1234_52B7;   // lui  x5,0x12345 (rs1 field = 8)
        romTable[3]   = 32'h0053_03B3;   // add  x7,x6,x5
        romTable[64]  = 32'h00A0_0093;   // addi x1,x0,10 at 0x100
        romTable[255] = 32'h0012_8333;   // add  x6,x5,x1 at 0xFFFFFFFC

        rst_n = 1'b1; EX_jump_i = 1'b0; EX_target_i = '0; EX_load_i = 1'b0; EX_rd_i = '0;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("lit_rst_IF_pc", IF_pc_o, 32'h0);
        checkOutput("lit_rst_ID_pc4", ID_pc4_o, 32'h4);
        checkOutput("lit_rst_ID_inst", ID_inst_o, NOP);
        checkOutput("lit_rst_valid", {31'b0, ID_valid_o}, 32'h0);

        // BOOT: a jump from EX must be ignored.
        applyStimulus(0, 1, 32'h200, 0, 0);
        checkOutput("lit_boot_flush", {31'b0, flush_o}, 32'h0);
        checkOutput("lit_boot_IF_pc", IF_pc_o, 32'h0);

        applyStimulus(0, 0, 0, 1, 5);
        checkOutput("lit_c1_ID_inst", ID_inst_o, 32'h0012_8333);
        checkOutput("lit_c1_IF_pc", IF_pc_o, 32'h4);
        checkOutput("lit_loaduse_stop", {31'b0, stop_o}, 32'h1);

        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("lit_hold_IF_pc", IF_pc_o, 32'h4);
        checkOutput("lit_hold_ID_inst", ID_inst_o, 32'h0012_8333);
        checkOutput("lit_rd0_stop", {31'b0, stop_o}, 32'h0);

        applyStimulus(0, 0, 0, 1, 5);
        checkOutput("lit_sw_ID_pc4", ID_pc4_o, 32'h8);
        checkOutput("lit_sw_stop", {31'b0, stop_o}, 32'h1);

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 8);
        checkOutput("lit_lui_stop", {31'b0, stop_o}, 32'h0);
        checkOutput("lit_lui_IF_pc", IF_pc_o, 32'hC);

        applyStimulus(0, 1, 32'h103, 1, 6);
        checkOutput("lit_jmp_haz_stop", {31'b0, stop_o}, 32'h0);
        checkOutput("lit_jmp_flush", {31'b0, flush_o}, 32'h1);

        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("lit_redir_IF_pc", IF_pc_o, 32'h100);
        checkOutput("lit_redir_ID_inst", ID_inst_o, NOP);
        checkOutput("lit_redir_valid", {31'b0, ID_valid_o}, 32'h0);

        applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0);
        checkOutput("lit_tgt_ID_inst", ID_inst_o, 32'h00A0_0093);
        checkOutput("lit_tgt_ID_pc", ID_pc_o, 32'h100);

        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("lit_top_IF_pc", IF_pc_o, 32'hFFFF_FFFC);

        applyStimulus(0, 0, 0, 1, 5);
        checkOutput("lit_wrap_IF_pc", IF_pc_o, 32'h0);
        checkOutput("lit_wrap_ID_pc4", ID_pc4_o, 32'h0);
        checkOutput("lit_wrap_stop", {31'b0, stop_o}, 32'h1);

        // Reset lands while the pipeline is stalled.
        applyStimulus(1, 0, 0, 1, 5);
`ifdef IF_ID_PERF_CNT_EN
        checkOutput("lit_stall_cnt", stallCnt, 32'd3);
        checkOutput("lit_flush_cnt", flushCnt, 32'd2);
`endif
        applyStimulus(0, 1, 32'h40, 0, 0);
        checkOutput("lit_midrst_IF_pc", IF_pc_o, 32'h0);
        checkOutput("lit_midrst_valid", {31'b0, ID_valid_o}, 32'h0);
        checkOutput("lit_midrst_boot", {31'b0, flush_o}, 32'h0);
`ifdef IF_ID_PERF_CNT_EN
        checkOutput("lit_midrst_stall_cnt", stallCnt, 32'd0);
        checkOutput("lit_midrst_flush_cnt", flushCnt, 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic        r, j, l;
            logic [31:0] t;
            logic [4:0]  rd;
            r   = ($urandom_range(0, 99) < 2);
            j   = ($urandom_range(0, 7) == 0);
            t   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 1023));
            l   = 1'($urandom_range(0, 1));
            cur = mIdInst;
            case ($urandom_range(0, 3))
                0:       rd = cur[19:15];
                1:       rd = cur[24:20];
                2:       rd = 5'd0;
                default: rd = 5'($urandom_range(0, 31));
            endcase
            applyStimulus(r, j, t, l, rd);
        end

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch-side front end of the 5-stage RV32I pipeline. It holds the PC, drives the instruction-ROM address, and latches the fetched word into the IF/ID register. It also detects load-use hazards and produces the `stop` consumed by the ID/EX register, and handles redirects from EX.
It sits directly upstream of the decode stage and the ID/EX register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/boot.

Ports:
clk  input  1  pipeline clock, all state updates on rising edge.
rst_n  input  1  synchronous, active-high reset (1 = reset).
IF_inst_i  input  32  instruction word returned combinationally by the IROM for IF_pc_o.
EX_jump_i  input  1  taken branch/jump resolved in EX.
EX_target_i  input  32  redirect target, valid when EX_jump_i=1.
EX_load_i  input  1  instruction currently in EX is a load.
EX_rd_i  input  5  destination register of the EX instruction.
IF_pc_o  output  32  current fetch PC, which is also the IROM address.
ID_pc_o  output  32  PC of the instruction in ID.
ID_pc4_o  output  32  ID_pc_o + 4.
ID_inst_o  output  32  instruction in ID.
ID_valid_o  output  1  ID holds a real instruction (0 = bubble).
stop_o  output  1  load-use stall request to the ID/EX register (combinational).
flush_o  output  1  squash request to the ID/EX register (combinational, equals the redirect condition).

Behaviour:
- Reset (rst_n=1 at edge):
  - IF_pc_o=RESET_PC, ID_pc_o=0, ID_pc4_o=4, ID_inst_o=NOP_INST, ID_valid_o=0.
  - FSM goes to BOOT.
- FSM states are BOOT, RUN, STALL, FLUSH.
  - BOOT: one cycle. IF/ID captures the fetch at RESET_PC, pc<=RESET_PC+4, next state RUN. If EX_jump_i is asserted in BOOT it is ignored, because EX holds reset state.
  - RUN: normal operation. pc<=pc+4 and IF/ID<= {IF_pc_o, IF_inst_i}, valid=1.
  - STALL: entered when a hazard is detected in RUN. While in it, pc and IF/ID hold. It exits to RUN when the hazard clears, which takes 1 cycle for a single load-use.
  - FLUSH: entered on redirect. pc<=EX_target_i and IF/ID<=NOP_INST with valid=0. Next state is RUN, unless another redirect arrives, in which case it stays in FLUSH.
- Hazard: haz = EX_load_i & (EX_rd_i!=0) & ID_valid_o & ((rs1==EX_rd_i) | (uses_rs2 & rs2==EX_rd_i)).
  - rs1=ID_inst_o[19:15], rs2=ID_inst_o[24:20].
  - uses_rs2=1 for opcodes 0110011 (R), 0100011 (S), 1100011 (B). rs1 is treated as used for all opcodes except LUI, AUIPC and JAL.
- stop_o = haz & ~EX_jump_i.
- flush_o = EX_jump_i (not in BOOT).
- Priority on simultaneous events: reset > redirect > stall > advance. A redirect arriving during a stall cancels the stall in the same cycle.
- Arithmetic: pc+4 wraps modulo 2^32 with no exception. The low 2 bits of EX_target_i are forced to 0 when loaded.
- Latency: instruction word at IF_pc_o appears on ID_inst_o one cycle later. Redirect penalty is 2 bubbles: this block's IF/ID squash plus the ID/EX squash driven by flush_o.
- Reset asserted mid-stall or mid-flush discards all state and returns to BOOT.

Optional Feature:
- Macro IF_ID_PERF_CNT_EN.
- When defined, add outputs:
  - stall_cnt_o[31:0]: increments on each cycle with stop_o=1.
  - flush_cnt_o[31:0]: increments on each cycle with flush_o=1.
  - Both reset to 0, saturate at 32'hFFFF_FFFF, and are never cleared except by reset.
- When not defined, these ports and their counters do not exist, and the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - opcode constants (OP_R, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL);
  - NOP_INST;
  - FSM state encoding (2-bit: BOOT=0, RUN=1, STALL=2, FLUSH=3).
- One sub-module, hazard_detect: purely combinational. Inputs are ID_inst, ID_valid, EX_load, EX_rd; output is haz.
- The FSM, PC register and IF/ID register stay in if_id_stage.

Test Plan:
- Reset then release → cycle 0: IF_pc_o=0, ID_valid_o=0. Cycle 1: ID_inst_o=IROM[0], IF_pc_o=4. Cycle 2: ID_pc4_o=8.
- lw x5 in EX (EX_load_i=1, EX_rd_i=5) with ID=add x6,x5,x1 → stop_o=1 for exactly 1 cycle, and IF_pc_o and ID_inst_o hold. The same case with EX_rd_i=0 gives stop_o=0.
- ID=sw x5,0(x2) with EX_rd_i=5 and a load in EX → stall (rs2 used). ID=lui x5 with EX_rd_i=5 → no stall.
- EX_jump_i=1, EX_target_i=0x100 → flush_o=1, next cycle IF_pc_o=0x100, ID_inst_o=0x00000013, ID_valid_o=0. The cycle after, ID_inst_o=IROM[0x100].
- Hazard and EX_jump_i in the same cycle → stop_o=0, redirect taken. Target 0x103 → IF_pc_o=0x100. PC=0xFFFFFFFC in RUN → next PC 0x0.
- With IF_ID_PERF_CNT_EN defined: 3 stalls and 2 flushes → stall_cnt_o=3, flush_cnt_o=2. Assert reset mid-stall → both counters 0 and FSM in BOOT.
